cordic_result_capture: RTL and testbench
========================================

# cordic_result_capture

Result-side counterpart to the CORDIC stimulus path. It tracks which input samples were issued into the fixed-latency `cordic` pipeline and captures the matching `res1`/`res2` pair when that sample emerges. Each captured pair is buffered in a FIFO and drained over a valid/ready handshake. The block sits between the `cordic` outputs and any consumer (result writer, checker, bus interface) and removes the need to hard-code a warm-up skip count.

## Interface

**Parameters**
- `WIDTH`, 16: width of `res1`/`res2` and of the captured data.
- `LATENCY`, 8: cordic pipeline depth in cycles; legal range 1–32.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.

**Ports**
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_valid`  in  1: a sample is presented to `cordic` this cycle.
- `in_mode`  in  1: mode bit of that sample; carried as a tag.
- `res1`  in  WIDTH: cordic result 1.
- `res2`  in  WIDTH: cordic result 2.
- `flush`  in  1: synchronous clear of the FIFO, the delay line, `overflow` and `drop_count`.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_res1`  out  WIDTH: head entry, result 1.
- `out_res2`  out  WIDTH: head entry, result 2.
- `out_mode`  out  1: head entry, mode tag.
- `count`  out  clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky flag; a result was dropped.
- `drop_count`  out  8: number of dropped results, saturating at 255.

## Operation

**Delay line**
- LATENCY-stage shift register of {valid, mode}. `in_valid`/`in_mode` enter stage 0 at every edge.
- The tap at stage LATENCY-1 is the push request; `res1`/`res2` are sampled in the same cycle the tap is high.

**Push / pop rules**
- pop = `out_valid` & `out_ready`.
- push = tap valid & (not full | pop).
- Full & tap valid & no pop: the result is dropped, `overflow` is set to 1, and `drop_count` increments (no change once at 255).
- Push and pop on the same edge: both take effect, `count` is unchanged. This holds when full and when `count`=1.
- Pop when empty cannot occur because `out_valid`=0; `out_ready` is then ignored.

**FIFO storage and output**
- Circular buffer with read and write pointers one bit wider than the address; both wrap modulo DEPTH.
- full = pointers differ only in the MSB; empty = pointers equal.
- `out_*` show the head entry combinationally from storage. When empty they hold the last read value, which is don't-care for verification.

**Flush**
- `flush` takes priority over push and pop on the same edge.
- Clears delay-line valids, pointers, `overflow` and `drop_count`. In-flight results are discarded.
- Storage contents are not cleared.

**Reset**
- Asynchronous reset has the same effect as flush, plus `out_res1`/`out_res2`/`out_mode` read 0.
- Reset values: `out_valid`=0, `count`=0, `overflow`=0, `drop_count`=0.
- Reset asserted mid-stream discards everything. The first capture after reset release is for the first `in_valid` sampled after release.

## Timing

- `in_valid` sampled at edge n: `res1`/`res2` are sampled at edge n+LATENCY-1 and written at that edge. `out_valid` rises after edge n+LATENCY-1 when the FIFO was empty.
- Pop at edge m: the next entry is on `out_*` and `count` decrements after edge m.
- Throughput: one push and one pop per cycle.
- The `res1`/`res2` presented with the tap must be the cordic outputs for the tagged sample. Aligning them is the integrator's job via LATENCY.
- No combinational path from `in_valid` to any output.
- The only combinational path from `out_ready` is to nothing; it affects state only.

## Test plan

- **Basic latency:** reset, LATENCY=8, one `in_valid` at edge 0 with `in_mode`=1, `res1`/`res2`=16'h1234/16'h5678 in cycle 7 → `out_valid`=1 after edge 7 with `out_res1`=16'h1234, `out_res2`=16'h5678, `out_mode`=1, `count`=1; `out_ready`=1 → `out_valid`=0 next cycle.
- **Gaps in the stream:** `in_valid` pattern 1,0,1,1 with distinct result values per cycle, `out_ready`=1 → exactly 3 entries in order; no capture in the gap cycle.
- **Overflow:** DEPTH=16, `out_ready`=0, 20 consecutive valids → `count`=16, `overflow`=1, `drop_count`=4. The 16 oldest values are kept and drain in order once `out_ready`=1.
- **Full with simultaneous push/pop:** full FIFO, tap valid and `out_ready`=1 in the same cycle → `count` stays 16, `drop_count` unchanged, new value appears at the tail.
- **Pointer wrap:** push and pop 40 entries with random `out_ready` → output sequence identical to input order, `overflow`=0.
- **Reset / flush mid-stream:** 5 results in flight and 3 buffered, then `reset` pulsed asynchronously (or `flush` held one cycle) → `out_valid`=0 and `count`=0 immediately, and no stale capture appears over the next LATENCY cycles.

Source files
------------

// File: rtl/cordic_result_capture.sv
// Captures cordic res1/res2 for each issued sample after a fixed pipeline latency
// and buffers {res1, res2, mode} in a FIFO drained over a valid/ready handshake.
module cordic_result_capture #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_mode,
  input  logic [WIDTH-1:0]         res1,
  input  logic [WIDTH-1:0]         res2,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_res1,
  output logic [WIDTH-1:0]         out_res2,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic tap_vld;
  logic tap_mode;

  // Delay line: stage 0 is the sampled input, so the tap lands LATENCY-1 edges later
  generate
    if (LATENCY == 1) begin : g_direct
      assign tap_vld  = in_valid;
      assign tap_mode = in_mode;
    end else begin : g_line
      logic [LATENCY-2:0] vld_p;
      logic [LATENCY-2:0] mode_p;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p  <= '0;
          mode_p <= '0;
        end else if (flush) begin
          vld_p  <= '0;
        end else begin
          vld_p[0]  <= in_valid;
          mode_p[0] <= in_mode;
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_p[i]  <= vld_p[i-1];
            mode_p[i] <= mode_p[i-1];
          end
        end
      end

      assign tap_vld  = vld_p[LATENCY-2];
      assign tap_mode = mode_p[LATENCY-2];
    end
  endgenerate

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WIDTH-1:0]  mem_res1 [DEPTH];
  logic [WIDTH-1:0]  mem_res2 [DEPTH];
  logic              mem_mode [DEPTH];
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign pop   = ~empty & out_ready;
  assign push  = tap_vld & (~full | pop);
  assign drop  = tap_vld & full & ~pop;

  // FIFO pointers; flush wins over any push/pop on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared only by reset so the head reads zero afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_res1[i] <= '0;
        mem_res2[i] <= '0;
        mem_mode[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      mem_res1[wr_ptr[AW-1:0]] <= res1;
      mem_res2[wr_ptr[AW-1:0]] <= res2;
      mem_mode[wr_ptr[AW-1:0]] <= tap_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc8(drop_count);
    end
  end

  assign out_valid = ~empty;
  assign count     = wr_ptr - rd_ptr;
  assign out_res1  = mem_res1[rd_ptr[AW-1:0]];
  assign out_res2  = mem_res2[rd_ptr[AW-1:0]];
  assign out_mode  = mem_mode[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_cordic_result_capture.sv
// Randomized bench for cordic_result_capture against a queue-based model of
// issued samples and buffered results.
module tb_cordic_result_capture;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 8;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_mode, flush, out_ready;
  logic [WIDTH-1:0]  res1, res2;
  logic              out_valid, out_mode, overflow;
  logic [WIDTH-1:0]  out_res1, out_res2;
  logic [4:0]        count;
  logic [7:0]        drop_count;

  cordic_result_capture #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
    .res1(res1), .res2(res2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_res1(out_res1), .out_res2(out_res2),
    .out_mode(out_mode), .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic m; } issue_t;
  typedef struct { logic [WIDTH-1:0] r1; logic [WIDTH-1:0] r2; logic m; } ent_t;

  issue_t inflight[$];
  ent_t   exp_q[$];
  int     edge_n = 0;
  logic   m_ovf  = 1'b0;
  int     m_drops = 0;
  int     checks = 0;
  int     errors = 0;
  int     dut_pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    inflight.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endfunction

  // Effect of the coming rising edge, from the currently driven inputs
  function automatic void model_edge();
    logic do_pop;
    logic tap;
    logic tm;
    do_pop = (exp_q.size() != 0) && out_ready;
    tap = 1'b0;
    tm  = 1'b0;
    if (flush) begin
      model_clear();
    end else begin
      if (in_valid) inflight.push_back('{edge_n + LATENCY - 1, in_mode});
      if (inflight.size() != 0 && inflight[0].due == edge_n) begin
        tap = 1'b1;
        tm  = inflight[0].m;
        void'(inflight.pop_front());
      end
      if (do_pop) void'(exp_q.pop_front());
      if (tap) begin
        if (exp_q.size() < DEPTH) exp_q.push_back('{res1, res2, tm});
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    edge_n++;
  endfunction

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    if (exp_q.size() != 0) begin
      chk("out_res1", 32'(out_res1), 32'(exp_q[0].r1));
      chk("out_res2", 32'(out_res2), 32'(exp_q[0].r2));
      chk("out_mode", 32'(out_mode), 32'(exp_q[0].m));
    end
  endtask

  task automatic step(input logic v, input logic m, input logic rdy, input logic fl,
                      input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2);
    in_valid  = v;
    in_mode   = m;
    out_ready = rdy;
    flush     = fl;
    res1      = r1;
    res2      = r2;
    if (out_valid && out_ready) dut_pops++;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rstep(input logic v, input logic rdy);
    step(v, 1'($urandom), rdy, 1'b0, WIDTH'($urandom), WIDTH'($urandom));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; flush = 1'b0; out_ready = 1'b0;
    res1 = '0; res2 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();
    chk("rst_res1", 32'(out_res1), 32'h0);
    chk("rst_res2", 32'(out_res2), 32'h0);
    chk("rst_mode", 32'(out_mode), 32'h0);

    // Basic latency
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
    repeat (LATENCY - 2) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    chk("lat_early_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_res1", 32'(out_res1), 32'h1234);
    chk("lat_res2", 32'(out_res2), 32'h5678);
    chk("lat_mode", 32'(out_mode), 32'h1);
    chk("lat_count", 32'(count), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("lat_drained", 32'(out_valid), 32'h0);

    // Gaps in the stream
    dut_pops = 0;
    rstep(1'b1, 1'b1); rstep(1'b0, 1'b1); rstep(1'b1, 1'b1); rstep(1'b1, 1'b1);
    repeat (LATENCY + 2) rstep(1'b0, 1'b1);
    chk("gap_pops", 32'(dut_pops), 32'd3);

    // Overflow, then full with simultaneous push/pop
    repeat (20) rstep(1'b1, 1'b0);
    repeat (LATENCY - 1) rstep(1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_drops", 32'(drop_count), 32'd4);
    rstep(1'b1, 1'b0);
    repeat (LATENCY - 2) rstep(1'b0, 1'b0);
    rstep(1'b0, 1'b1);
    chk("full_pp_count", 32'(count), 32'd16);
    chk("full_pp_drops", 32'(drop_count), 32'd4);
    repeat (20) rstep(1'b0, 1'b1);
    chk("ovf_drained", 32'(count), 32'd0);

    // Drop counter saturation, then flush clears status
    repeat (300) rstep(1'b1, 1'b0);
    repeat (LATENCY - 1) rstep(1'b0, 1'b0);
    chk("sat_drops", 32'(drop_count), 32'd255);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_drops", 32'(drop_count), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'h0);

    // Pointer wrap with mostly-ready consumer
    dut_pops = 0;
    repeat (40) rstep(1'b1, 1'($urandom_range(0, 7) != 0));
    repeat (DEPTH + LATENCY + 4) rstep(1'b0, 1'b1);
    chk("wrap_pops", 32'(dut_pops), 32'd40);
    chk("wrap_ovf", 32'(overflow), 32'h0);

    // Flush mid-stream: 3 buffered, 5 in flight
    repeat (3) rstep(1'b1, 1'b0);
    repeat (LATENCY) rstep(1'b0, 1'b0);
    repeat (5) rstep(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("flush_count", 32'(count), 32'd0);
    repeat (LATENCY + 1) rstep(1'b0, 1'b0);

    // Asynchronous reset mid-stream: 3 buffered, 5 in flight
    repeat (3) rstep(1'b1, 1'b0);
    repeat (LATENCY) rstep(1'b0, 1'b0);
    repeat (5) rstep(1'b1, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_res1", 32'(out_res1), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_all();
    repeat (LATENCY + 1) rstep(1'b0, 1'b0);

    // Random mix including occasional flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0)
        step(1'b0, 1'b0, 1'($urandom), 1'b1, WIDTH'($urandom), WIDTH'($urandom));
      else
        rstep(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
